// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, types and helpers for the VGA pattern generator.
// Active area size, pattern state encoding, colour-bar table and box axis type.
package vga_pkg;

    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned BAR_COUNT = 8;
    localparam int unsigned BAR_W     = H_ACTIVE / BAR_COUNT;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_BOX      = 2'd3
    } pattern_e;

    // {r,g,b} full-scale flags, leftmost bar first:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_RGB [0:BAR_COUNT-1] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    // One axis of the bouncing box: position plus direction (neg=1 moves toward 0)
    typedef struct packed {
        logic       neg;
        logic [9:0] pos;
    } box_axis_t;

    // Bar number for a column, found by threshold compares instead of a divider
    function automatic logic [2:0] bar_index(input logic [9:0] x);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 1; i < BAR_COUNT; i++) begin
            if (x >= 10'(i * BAR_W)) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// vga_box_mover: position and direction of the bouncing box, stepped once per
// frame start; each axis clamps to its edge and reverses when it gets there.
import vga_pkg::*;

module vga_box_mover #(
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned BOX_STEP = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       step_i,
    output logic [9:0] box_x_o,
    output logic [9:0] box_y_o
);

    // Far-edge positions are the last column/row where the box still fits
    localparam logic [10:0] X_FAR = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_FAR = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP  = 11'(BOX_STEP);

    box_axis_t x_q, x_d;
    box_axis_t y_q, y_d;

    // Reaching an edge exactly counts as a bounce, so the box turns on the edge frame
    function automatic box_axis_t move_axis(input box_axis_t a, input logic [10:0] far);
        box_axis_t   n;
        logic [10:0] p;
        p = {1'b0, a.pos};
        n = a;
        if (!a.neg) begin
            if (p + STEP >= far) begin
                n.pos = far[9:0];
                n.neg = 1'b1;
            end else begin
                n.pos = a.pos + STEP[9:0];
            end
        end else begin
            if (p <= STEP) begin
                n.pos = '0;
                n.neg = 1'b0;
            end else begin
                n.pos = a.pos - STEP[9:0];
            end
        end
        return n;
    endfunction

    // Next position: move both axes on a frame start, otherwise hold
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (step_i) begin
            x_d = move_axis(x_q, X_FAR);
            y_d = move_axis(y_q, Y_FAR);
        end
    end

    // Position registers; reset to the top-left corner moving +x,+y
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign box_x_o = x_q.pos;
    assign box_y_o = y_q.pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: re-registers upstream VGA syncs and generates a test pattern
// (bars, checker, gradient) aligned with them; next_pat advances the pattern at
// the following frame start. Define VGA_PATTERN_BOX_EN to add the bouncing-box
// pattern as a fourth state.
import vga_pkg::*;

module vga_pattern_gen #(
    parameter int unsigned COLOR_W         = 4,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned BOX_SIZE        = 32,
    parameter int unsigned BOX_STEP        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               active_in,
    input  logic [9:0]         x_in,
    input  logic [9:0]         y_in,
    input  logic               next_pat,
    output logic               hs,
    output logic               vs,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic [1:0]         pattern_id,
    output logic [7:0]         frame_cnt
);

    if (COLOR_W < 4 || COLOR_W > 8 || BOX_SIZE == 0 || BOX_SIZE > V_ACTIVE || BOX_STEP == 0)
    begin : g_bad_params
        $error("vga_pattern_gen: parameter out of range");
    end

    localparam logic               SYNC_IDLE = SYNC_ACTIVE_LOW;
    localparam logic [COLOR_W-1:0] FULL      = '1;

    logic               hs_q, vs_q;
    logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    pattern_e           state_q;
    logic               pend_q;
    logic [7:0]         frame_cnt_q;
    logic               frame_start;
    logic               pixel_ok;
    logic [2:0]         bar_rgb;

    // vs_q doubles as the one-cycle vs history used for edge detection
    assign frame_start = (vs_in != SYNC_IDLE) && (vs_q == SYNC_IDLE);
    // Coordinates outside the visible area are blanked as well
    assign pixel_ok    = active_in && (x_in < 10'(H_ACTIVE)) && (y_in < 10'(V_ACTIVE));
    assign bar_rgb     = BAR_RGB[bar_index(x_in)];

`ifdef VGA_PATTERN_BOX_EN
    logic [9:0] box_x, box_y;
    logic       in_box;

    vga_box_mover #(
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .clk_i   (clk),
        .rst_i   (rst),
        .step_i  (frame_start),
        .box_x_o (box_x),
        .box_y_o (box_y)
    );

    // 11-bit compares so box_x + BOX_SIZE cannot wrap
    assign in_box = ({1'b0, x_in} >= {1'b0, box_x}) &&
                    ({1'b0, x_in} <  ({1'b0, box_x} + 11'(BOX_SIZE))) &&
                    ({1'b0, y_in} >= {1'b0, box_y}) &&
                    ({1'b0, y_in} <  ({1'b0, box_y} + 11'(BOX_SIZE)));
`endif

    // Colour of the pixel being presented this cycle under the current pattern
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (pixel_ok) begin
            case (state_q)
                PAT_BARS: begin
                    r_d = {COLOR_W{bar_rgb[2]}};
                    g_d = {COLOR_W{bar_rgb[1]}};
                    b_d = {COLOR_W{bar_rgb[0]}};
                end
                PAT_CHECKER: begin
                    if (x_in[5] ^ y_in[5]) begin
                        r_d = FULL;
                        g_d = FULL;
                        b_d = FULL;
                    end
                end
                PAT_GRADIENT: begin
                    r_d = x_in[9 -: COLOR_W];
                    g_d = y_in[8 -: COLOR_W];
                end
`ifdef VGA_PATTERN_BOX_EN
                PAT_BOX: begin
                    if (in_box) r_d = FULL;
                    else        b_d = FULL;
                end
`endif
                default: ;
            endcase
        end
    end

    // Output pipeline: syncs and colour share one register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q <= SYNC_IDLE;
            vs_q <= SYNC_IDLE;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else begin
            hs_q <= hs_in;
            vs_q <= vs_in;
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
        end
    end

    // Pattern FSM, pending request and frame counter, all updated on frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PAT_BARS;
            pend_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            pend_q      <= 1'b0;
            if (pend_q || next_pat) begin
                case (state_q)
                    PAT_BARS:     state_q <= PAT_CHECKER;
                    PAT_CHECKER:  state_q <= PAT_GRADIENT;
`ifdef VGA_PATTERN_BOX_EN
                    PAT_GRADIENT: state_q <= PAT_BOX;
`endif
                    default:      state_q <= PAT_BARS;
                endcase
            end
        end else if (next_pat) begin
            pend_q <= 1'b1;
        end
    end

    assign hs         = hs_q;
    assign vs         = vs_q;
    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign pattern_id = state_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: randomized self-checking bench for vga_pattern_gen
// against a behavioural model of the pattern rules.
module tb_vga_pattern_gen;

    localparam int unsigned CW  = 4;
    localparam int          BSZ = 32;
    localparam int          BST = 2;
`ifdef VGA_PATTERN_BOX_EN
    localparam int          NPAT = 4;
`else
    localparam int          NPAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          hs_in, vs_in, active_in, next_pat;
    logic [9:0]    x_in, y_in;
    logic          hs, vs;
    logic [CW-1:0] r, g, b;
    logic [1:0]    pattern_id;
    logic [7:0]    frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int            m_pat, m_cnt, m_bx, m_by, m_dx, m_dy;
    bit            m_pend, m_prev_vs;
    logic          e_hs, e_vs;
    logic [CW-1:0] e_r, e_g, e_b;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .COLOR_W         (CW),
        .SYNC_ACTIVE_LOW (1'b1),
        .BOX_SIZE        (BSZ),
        .BOX_STEP        (BST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .active_in  (active_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .next_pat   (next_pat),
        .hs         (hs),
        .vs         (vs),
        .r          (r),
        .g          (g),
        .b          (b),
        .pattern_id (pattern_id),
        .frame_cnt  (frame_cnt)
    );

    task automatic model_reset();
        m_pat = 0; m_cnt = 0; m_pend = 0; m_prev_vs = 1;
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    endtask

    function automatic void ref_pixel(input int pat, input int x, input int y,
                                      output int rr, output int gg, output int bb);
        int f, bar;
        f = (1 << CW) - 1;
        rr = 0; gg = 0; bb = 0;
        case (pat)
            0: begin
                bar = x / 80;
                rr = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? f : 0;
                gg = (bar <= 3) ? f : 0;
                bb = (bar == 0 || bar == 2 || bar == 4 || bar == 6) ? f : 0;
            end
            1: if (((x / 32) + (y / 32)) % 2 == 1) begin rr = f; gg = f; bb = f; end
            2: begin
                rr = x >> (10 - CW);
                gg = (y >> (9 - CW)) % (1 << CW);
            end
            default: begin
                if (x >= m_bx && x < m_bx + BSZ && y >= m_by && y < m_by + BSZ) rr = f;
                else bb = f;
            end
        endcase
    endfunction

    task automatic move_axis(inout int pos, inout int dir, input int far);
        pos = pos + dir * BST;
        if (pos >= far) begin pos = far; dir = -1; end
        else if (pos <= 0) begin pos = 0; dir = 1; end
    endtask

    // apply current inputs for one clock, updating the model (no checks here)
    task automatic cycle();
        int rr, gg, bb;
        e_hs = hs_in;
        e_vs = vs_in;
        rr = 0; gg = 0; bb = 0;
        if (active_in) ref_pixel(m_pat, int'(x_in), int'(y_in), rr, gg, bb);
        e_r = CW'(rr); e_g = CW'(gg); e_b = CW'(bb);
        if (vs_in == 1'b0 && m_prev_vs == 1'b1) begin
            m_cnt = (m_cnt + 1) % 256;
            if (m_pend || next_pat) m_pat = (m_pat + 1) % NPAT;
            m_pend = 0;
            move_axis(m_bx, m_dx, 640 - BSZ);
            move_axis(m_by, m_dy, 480 - BSZ);
        end else if (next_pat) begin
            m_pend = 1;
        end
        m_prev_vs = vs_in;
        @(posedge clk);
        #1;
        next_pat = 1'b0;
    endtask

    task automatic frame();
        active_in = 1'b0;
        vs_in = 1'b0;
        cycle();
        vs_in = 1'b1;
        cycle();
    endtask

    task automatic hold_reset();
        active_in = 1'b0; next_pat = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({hs, vs, r, g, b, pattern_id, frame_cnt} !== {1'b1, 1'b1, {3*CW{1'b0}}, 2'd0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_hold: got hs=%b vs=%b rgb=%h/%h/%h pat=%0d cnt=%0d want 1 1 0/0/0 0 0",
                     hs, vs, r, g, b, pattern_id, frame_cnt);
        end
        rst = 1'b0;
        next_pat = 1'b1; vs_in = 1'b0; hs_in = 1'b0; active_in = 1'b0;
        cycle();
        vs_in = 1'b0; active_in = 1'b1; x_in = 10'd100; y_in = 10'd40;
        cycle();
        n_vec++;
        if (pattern_id !== 2'(m_pat) || frame_cnt !== 8'(m_cnt)) begin
            n_err++;
            $display("FAIL pre_async_state: got pat=%0d cnt=%0d want pat=%0d cnt=%0d",
                     pattern_id, frame_cnt, m_pat, m_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (hs !== 1'b1 || vs !== 1'b1) begin
            n_err++;
            $display("FAIL async_sync: got hs=%b vs=%b want 1 1", hs, vs);
        end
        n_vec++;
        if ({r, g, b} !== '0) begin
            n_err++;
            $display("FAIL async_rgb: got %h/%h/%h want 0/0/0", r, g, b);
        end
        n_vec++;
        if (pattern_id !== 2'd0 || frame_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL async_state: got pat=%0d cnt=%0d want 0 0", pattern_id, frame_cnt);
        end
        hold_reset();
    endtask

    task automatic test_yellow();
        active_in = 1'b1; x_in = 10'd85; y_in = 10'd0; hs_in = 1'b1; vs_in = 1'b1;
        cycle();
        n_vec++;
        if ({r, g, b} !== {4'hF, 4'hF, 4'h0} || pattern_id !== 2'd0) begin
            n_err++;
            $display("FAIL yellow_bar: got rgb=%h/%h/%h pat=%0d want f/f/0 pat=0", r, g, b, pattern_id);
        end
    endtask

    task automatic test_blank();
        logic hs_prev;
        for (int i = 0; i < 4; i++) begin
            active_in = 1'b0; x_in = 10'd10; y_in = 10'($urandom_range(479, 0));
            hs_in = 1'($urandom_range(1, 0)); vs_in = 1'b1;
            hs_prev = hs_in;
            cycle();
            n_vec++;
            if ({r, g, b} !== '0 || hs !== hs_prev || vs !== 1'b1) begin
                n_err++;
                $display("FAIL blank: got rgb=%h/%h/%h hs=%b vs=%b want 0/0/0 hs=%b vs=1",
                         r, g, b, hs, vs, hs_prev);
            end
        end
    endtask

    task automatic test_random_pixels();
        for (int p = 0; p < NPAT; p++) begin
            for (int i = 0; i < 40; i++) begin
                vs_in = 1'b1;
                hs_in = 1'($urandom_range(1, 0));
                active_in = ($urandom_range(3, 0) != 0);
                if (m_pat == 3 && $urandom_range(1, 0) == 1) begin
                    x_in = 10'(m_bx + $urandom_range(BSZ + 1, 0) - 1 < 0 ? 0 :
                               m_bx + $urandom_range(BSZ + 1, 0) - 1);
                    y_in = 10'(m_by + $urandom_range(BSZ - 1, 0));
                end else begin
                    x_in = 10'($urandom_range(639, 0));
                    y_in = 10'($urandom_range(479, 0));
                end
                if (i == 20) next_pat = 1'b1;
                cycle();
                n_vec++;
                if ({hs, vs, r, g, b} !== {e_hs, e_vs, e_r, e_g, e_b}) begin
                    n_err++;
                    $display("FAIL pixel pat%0d x=%0d y=%0d: got hs=%b vs=%b rgb=%h/%h/%h want hs=%b vs=%b rgb=%h/%h/%h",
                             m_pat, x_in, y_in, hs, vs, r, g, b, e_hs, e_vs, e_r, e_g, e_b);
                end
                n_vec++;
                if (pattern_id !== 2'(m_pat)) begin
                    n_err++;
                    $display("FAIL midframe_pattern: got %0d want %0d", pattern_id, m_pat);
                end
            end
            frame();
        end
    endtask

    task automatic test_multi_pulse();
        int p0;
        p0 = m_pat;
        for (int i = 0; i < 3; i++) begin
            next_pat = 1'b1;
            cycle();
            cycle();
        end
        n_vec++;
        if (pattern_id !== 2'(p0)) begin
            n_err++;
            $display("FAIL multi_pulse_hold: got %0d want %0d", pattern_id, p0);
        end
        frame();
        n_vec++;
        if (pattern_id !== 2'((p0 + 1) % NPAT)) begin
            n_err++;
            $display("FAIL multi_pulse_advance: got %0d want %0d", pattern_id, (p0 + 1) % NPAT);
        end
        frame();
        n_vec++;
        if (pattern_id !== 2'((p0 + 1) % NPAT)) begin
            n_err++;
            $display("FAIL multi_pulse_single: got %0d want %0d", pattern_id, (p0 + 1) % NPAT);
        end
    endtask

    task automatic test_coincident();
        int p0;
        p0 = m_pat;
        next_pat = 1'b1; vs_in = 1'b0; active_in = 1'b0;
        cycle();
        n_vec++;
        if (pattern_id !== 2'((p0 + 1) % NPAT)) begin
            n_err++;
            $display("FAIL coincident_advance: got %0d want %0d", pattern_id, (p0 + 1) % NPAT);
        end
        vs_in = 1'b1;
        cycle();
        frame();
        n_vec++;
        if (pattern_id !== 2'((p0 + 1) % NPAT)) begin
            n_err++;
            $display("FAIL coincident_not_pending: got %0d want %0d", pattern_id, (p0 + 1) % NPAT);
        end
    endtask

    task automatic test_reset_midframe();
        frame();
        vs_in = 1'b0;
        cycle();
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        n_vec++;
        if (frame_cnt !== 8'd1 || frame_cnt !== 8'(m_cnt) || pattern_id !== 2'd0) begin
            n_err++;
            $display("FAIL reset_first_frame: got cnt=%0d pat=%0d want cnt=1 pat=0", frame_cnt, pattern_id);
        end
        vs_in = 1'b1;
        cycle();
    endtask

    task automatic test_wrap();
        hold_reset();
        repeat (255) frame();
        n_vec++;
        if (frame_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL wrap_255: got %0d want 255", frame_cnt);
        end
        frame();
        n_vec++;
        if (frame_cnt !== 8'd0 || frame_cnt !== 8'(m_cnt)) begin
            n_err++;
            $display("FAIL wrap_0: got %0d want 0", frame_cnt);
        end
    endtask

`ifdef VGA_PATTERN_BOX_EN
    task automatic check_box_pixels(input string tag, input int xs [4], input bit red [4]);
        for (int i = 0; i < 4; i++) begin
            active_in = 1'b1; vs_in = 1'b1;
            x_in = 10'(xs[i]); y_in = 10'(m_by);
            cycle();
            n_vec++;
            if ({r, g, b} !== (red[i] ? {4'hF, 4'h0, 4'h0} : {4'h0, 4'h0, 4'hF})) begin
                n_err++;
                $display("FAIL %s x=%0d: got rgb=%h/%h/%h want %s", tag, xs[i], r, g, b,
                         red[i] ? "red" : "blue");
            end
        end
    endtask

    task automatic test_box();
        hold_reset();
        for (int i = 0; i < 3; i++) begin
            next_pat = 1'b1;
            frame();
        end
        n_vec++;
        if (pattern_id !== 2'd3) begin
            n_err++;
            $display("FAIL box_state: got %0d want 3", pattern_id);
        end
        for (int i = 0; i < 400 && !(m_bx == 606 && m_dx > 0); i++) frame();
        check_box_pixels("box_606", '{606, 605, 637, 638}, '{1'b1, 1'b0, 1'b1, 1'b0});
        frame();
        check_box_pixels("box_608", '{608, 607, 639, 606}, '{1'b1, 1'b0, 1'b1, 1'b0});
        frame();
        check_box_pixels("box_back", '{606, 605, 637, 639}, '{1'b1, 1'b0, 1'b1, 1'b0});
    endtask
`endif

    initial begin
        rst = 1'b1; hs_in = 1'b1; vs_in = 1'b1; active_in = 1'b0; next_pat = 1'b0;
        x_in = '0; y_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_yellow();
        test_blank();
        test_random_pixels();
        test_multi_pulse();
        test_coincident();
        test_reset_midframe();
        test_wrap();
`ifdef VGA_PATTERN_BOX_EN
        test_box();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
